// File: rtl/fp_sqrt_unit.sv
// ============================================================================
// fp_sqrt_unit : IEEE-754 single-precision square root, restoring recurrence.
// Optional denormal support via FP_SQRT_DENORM_EN (default: flush to zero).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp_sqrt_unit #(
    parameter  int OPCODE  = 3,
    localparam int LATENCY = 28
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reset_req,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    input  logic [7:0]  n,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [7:0]  c_OPCODE    = 8'(OPCODE);
    // start, unpack, round and done edges bracket the iteration phase
    localparam logic [4:0]  c_ITER_LAST = 5'(LATENCY - 4);
    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;
    localparam logic [31:0] c_PINF      = 32'h7F80_0000;

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

    state_t       r_state;
    logic [31:0]  r_a;
    logic [7:0]   r_n;
    logic [49:0]  r_rad;
    logic [27:0]  r_rem;
    logic [24:0]  r_root;
    logic [4:0]   r_cnt;
    logic [7:0]   r_exp;
    logic         r_special;
    logic [31:0]  r_spec_val;
    logic [31:0]  r_rounded;

    logic         w_unused;
    assign w_unused = ^{reset_req, datab};

    logic         w_sign;
    logic [7:0]   w_bexp;
    logic [22:0]  w_frac;
    assign w_sign = r_a[31];
    assign w_bexp = r_a[30:23];
    assign w_frac = r_a[22:0];

`ifdef FP_SQRT_DENORM_EN
    logic [4:0]   w_lzc;
    always_comb begin
        w_lzc = 5'd0;
        for (int i = 0; i < 23; i++) begin
            if (w_frac[i]) w_lzc = 5'(23 - i);
        end
    end
`endif

    logic [23:0]        w_mant;
    logic signed [9:0]  w_e;
    logic               w_is_special;
    logic [31:0]        w_spec_val;
    logic [49:0]        w_rad;

    always_comb begin
        w_mant       = {1'b1, w_frac};
        w_e          = $signed({2'b00, w_bexp}) - 10'sd127;
        w_is_special = 1'b1;
        w_spec_val   = c_QNAN;
        if (r_n != c_OPCODE) begin
            w_spec_val = c_QNAN;
        end else if (w_bexp == 8'hFF) begin
            w_spec_val = (w_frac == 23'd0 && !w_sign) ? c_PINF : c_QNAN;
        end else if (w_bexp == 8'h00 && w_frac == 23'd0) begin
            w_spec_val = {w_sign, 31'd0};
        end else if (w_bexp == 8'h00) begin
`ifdef FP_SQRT_DENORM_EN
            if (w_sign) begin
                w_spec_val = c_QNAN;
            end else begin
                w_is_special = 1'b0;
                w_mant       = {1'b0, w_frac} << w_lzc;
                w_e          = -10'sd126 - $signed({5'b00000, w_lzc});
            end
`else
            w_spec_val = {w_sign, 31'd0};
`endif
        end else if (w_sign) begin
            w_spec_val = c_QNAN;
        end else begin
            w_is_special = 1'b0;
        end
        // An odd exponent moves one factor of two into the radicand
        w_rad = w_e[0] ? {w_mant, 26'd0} : {1'b0, w_mant, 25'd0};
    end

    logic [27:0] w_rem_sh;
    logic [27:0] w_trial;
    logic [27:0] w_diff;
    logic        w_ge;
    assign w_rem_sh = {r_rem[25:0], r_rad[49:48]};
    assign w_trial  = {1'b0, r_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);
    assign w_diff   = w_rem_sh - w_trial;

    // root[24:1] holds the significand, root[0] is the guard bit
    logic        w_up;
    logic [24:0] w_sum;
    logic        w_carry;
    logic [22:0] w_frac_out;
    logic [7:0]  w_exp_out;
    assign w_up       = r_root[0] & ((|r_rem) | r_root[1]);
    assign w_sum      = {1'b0, r_root[24:1]} + 25'(w_up);
    assign w_carry    = w_sum[24];
    assign w_frac_out = w_carry ? w_sum[23:1] : w_sum[22:0];
    assign w_exp_out  = r_exp + 8'(w_carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            done       <= 1'b0;
            result     <= 32'd0;
            r_a        <= 32'd0;
            r_n        <= 8'd0;
            r_rad      <= 50'd0;
            r_rem      <= 28'd0;
            r_root     <= 25'd0;
            r_cnt      <= 5'd0;
            r_exp      <= 8'd0;
            r_special  <= 1'b0;
            r_spec_val <= 32'd0;
            r_rounded  <= 32'd0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // the cycle showing done still belongs to the last operation
                    if (start && !done) begin
                        r_a     <= dataa;
                        r_n     <= n;
                        r_state <= UNPACK;
                    end
                end
                UNPACK: begin
                    r_rad      <= w_rad;
                    r_exp      <= 8'((w_e >>> 1) + 10'sd127);
                    r_special  <= w_is_special;
                    r_spec_val <= w_spec_val;
                    r_rem      <= 28'd0;
                    r_root     <= 25'd0;
                    r_cnt      <= 5'd0;
                    r_state    <= ITER;
                end
                ITER: begin
                    r_rad <= {r_rad[47:0], 2'b00};
                    if (w_ge) begin
                        r_rem  <= w_diff;
                        r_root <= {r_root[23:0], 1'b1};
                    end else begin
                        r_rem  <= w_rem_sh;
                        r_root <= {r_root[23:0], 1'b0};
                    end
                    if (r_cnt == c_ITER_LAST) begin
                        r_state <= ROUND;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                ROUND: begin
                    r_rounded <= r_special ? r_spec_val : {1'b0, w_exp_out, w_frac_out};
                    r_state   <= DONE;
                end
                DONE: begin
                    result  <= r_rounded;
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_sqrt_unit.sv
// ============================================================================
// tb_fp_sqrt_unit : directed vectors, corner sequences and random operands
// checked against a real-arithmetic square-root model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp_sqrt_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        reset_req;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [7:0]  n;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    fp_sqrt_unit #(.OPCODE(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .reset_req (reset_req),
        .clk_en    (clk_en),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .n         (n),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] a;
        logic [7:0]  nn;
        logic [31:0] exp;
    } vec_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real v = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) v = v * 2.0;
        else        for (int i = 0; i < -e; i++) v = v / 2.0;
        return v;
    endfunction

    // double sqrt of a float, rounded once to float, is correctly rounded
    function automatic logic [31:0] ref_sqrt(input logic [31:0] a, input logic [7:0] nn);
        int    e;
        real   v, f, sc, fl;
        longint m;
        if (nn != 8'd3) return QNAN;
        if (a[30:23] == 8'hFF) return (a[22:0] == 23'd0 && !a[31]) ? PINF : QNAN;
        if (a[30:0] == 31'd0) return {a[31], 31'd0};
        if (a[30:23] == 8'h00) begin
`ifdef FP_SQRT_DENORM_EN
            if (a[31]) return QNAN;
            v = real'(a[22:0]) * pow2(-149);
`else
            return {a[31], 31'd0};
`endif
        end else begin
            if (a[31]) return QNAN;
            v = (1.0 + real'(a[22:0]) * pow2(-23)) * pow2(int'(a[30:23]) - 127);
        end
        f = $sqrt(v);
        e = 0;
        while (f >= 2.0) begin f = f / 2.0; e++; end
        while (f < 1.0)  begin f = f * 2.0; e--; end
        sc = f * 8388608.0;
        fl = $floor(sc);
        m  = longint'(fl);
        if ((sc - fl) > 0.5 || ((sc - fl) == 0.5 && m[0])) m++;
        if (m == 64'd16777216) begin m = m / 2; e++; end
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    // returns the result seen with done and the enabled-edge count to it
    task automatic run_op(input logic [31:0] a, input logic [7:0] nn, input bit stall,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        dataa = a; n = nn; start = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dataa = $urandom;
        lat = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            clk_en    = stall ? ($urandom_range(3) != 0) : 1'b1;
            start     = stall ? 1'($urandom_range(1)) : 1'b0;
            dataa     = $urandom;
            reset_req = 1'($urandom_range(1));
            @(posedge clk); #1;
            if (clk_en) lat++;
            if (done) break;
        end
        res = result;
        @(negedge clk);
        clk_en = 1'b1; start = 1'b0; reset_req = 1'b0;
    endtask

    vec_t        vecs[11];
    logic [31:0] res;
    logic [31:0] a;
    logic [7:0]  nn;
    int          lat;
    int          raw;
    int          dcount;

    initial begin
        vecs[0]  = '{32'h4080_0000, 8'd3, 32'h4000_0000};
        vecs[1]  = '{32'h4000_0000, 8'd3, 32'h3FB5_04F3};
        vecs[2]  = '{32'h3F80_0000, 8'd3, 32'h3F80_0000};
        vecs[3]  = '{32'h4110_0000, 8'd3, 32'h4040_0000};
        vecs[4]  = '{32'hC080_0000, 8'd3, QNAN};
        vecs[5]  = '{32'h7F80_0000, 8'd3, PINF};
        vecs[6]  = '{32'h8000_0000, 8'd3, 32'h8000_0000};
        vecs[7]  = '{32'h4080_0000, 8'd5, QNAN};
`ifdef FP_SQRT_DENORM_EN
        vecs[8]  = '{32'h0000_0001, 8'd3, 32'h1A35_04F3};
`else
        vecs[8]  = '{32'h0000_0001, 8'd3, 32'h0000_0000};
`endif
        vecs[9]  = '{32'h7FC0_0001, 8'd3, QNAN};
        vecs[10] = '{32'hFF80_0000, 8'd3, QNAN};

        rst = 1'b1; clk_en = 1'b1; start = 1'b0; reset_req = 1'b0;
        dataa = 32'd0; datab = 32'd0; n = 8'd3;
        @(posedge clk); #1;
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].nn, 1'b0, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd28);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_drop", i), 32'(done), 32'd0);
        end

        // clk_en low for 5 cycles mid-operation, with a stray start inside the stall
        @(negedge clk);
        dataa = 32'h4080_0000; n = 8'd3; start = 1'b1; clk_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; raw = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            clk_en = !(c >= 10 && c <= 14);
            start  = (c == 12);
            dataa  = (c == 12) ? 32'h4110_0000 : 32'h4080_0000;
            @(posedge clk); #1;
            if (done) begin raw = c; break; end
        end
        @(negedge clk); clk_en = 1'b1; start = 1'b0;
        check("stall_cycles", 32'(raw), 32'd33);
        check("stall_result", result, 32'h4000_0000);

        // a start during the done cycle must not launch an operation
        run_op(32'h3F80_0000, 8'd3, 1'b0, res, lat);
        check("pre_ignore_result", res, 32'h3F80_0000);
        start = 1'b1; dataa = 32'h4110_0000;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("done_cycle_start_ignored", 32'(dcount), 32'd0);
        check("done_cycle_result_held", result, 32'h3F80_0000);

        // reset during an operation aborts it silently
        @(negedge clk);
        dataa = 32'h4110_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dcount = 0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_no_done_before", 32'(dcount), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        run_op(32'h4000_0000, 8'd3, 1'b0, res, lat);
        check("after_abort_result", res, 32'h3FB5_04F3);
        check("after_abort_latency", 32'(lat), 32'd28);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(3) != 0) a[31] = 1'b0;
            if ($urandom_range(9) == 0) a[30:23] = 8'h00;
            if ($urandom_range(19) == 0) a[30:23] = 8'hFF;
            nn = ($urandom_range(9) == 0) ? 8'($urandom) : 8'd3;
            datab = $urandom;
            run_op(a, nn, 1'(i % 2), res, lat);
            check($sformatf("rand%0d_result a=%08h n=%0d", i, a, nn), res, ref_sqrt(a, nn));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'd28);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
